// File: rtl/fpu_arb_pkg.sv
// ============================================================================
// Module  : fpu_arb_pkg
// Brief   : Shared constants and helper functions for the FPU unit arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_arb_pkg;

    localparam int C_NREQ_MAX = 8;
    localparam int C_LAT_MAX  = 8;

    // Requester-id width; never below one bit so a single-requester build elaborates.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_arb_fifo.sv
// ============================================================================
// Module  : fpu_arb_fifo
// Brief   : Circular result FIFO; the head entry is presented combinationally.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_arb_fifo
    import fpu_arb_pkg::*;
#(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_W'(DEPTH));
    assign count    = r_count;
    assign w_do_pop = pop && !empty;
    // Zero the head when empty so the outputs read 0 out of reset.
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

`default_nettype wire

// File: rtl/fpu_unit_arbiter.sv
// ============================================================================
// Module  : fpu_unit_arbiter
// Brief   : Round-robin sharing of a fixed-latency, non-stallable FPU unit with
//           credit-protected tagged result FIFO. FPU_ARB_STAT_EN adds counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_unit_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int LAT    = 1,
    parameter int TAG_W  = 4,
    parameter int QDEPTH = LAT + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*32-1:0]        req_x,
    input  logic [NREQ*TAG_W-1:0]     req_tag,
    output logic [31:0]               unit_x,
    input  logic [31:0]               unit_y,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [31:0]               res_y,
    output logic [$clog2(NREQ)-1:0]   res_id,
`ifdef FPU_ARB_STAT_EN
    output logic [TAG_W-1:0]          res_tag,
    output logic [NREQ*32-1:0]        stat_issue,
    output logic [31:0]               stat_stall
`else
    output logic [TAG_W-1:0]          res_tag
`endif
);

    localparam int ID_W  = id_width(NREQ);
    localparam int CNT_W = cnt_width(QDEPTH);
    localparam int RES_W = 32 + ID_W + TAG_W;

    typedef struct packed {
        logic             v;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef struct packed {
        logic [31:0]      y;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } res_entry_t;

    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_credit_cnt;
    tag_entry_t       r_tag_pipe [LAT];

    logic             w_credit_ok;
    logic             w_grant_found;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W:0]    w_scan;
    logic [ID_W:0]    w_next_sum;
    logic [ID_W-1:0]  w_next_ptr;
    logic             w_xfer;
    logic             w_pop;
    logic [31:0]      w_sel_x;
    logic [TAG_W-1:0] w_sel_tag;
    res_entry_t       w_push_data;
    res_entry_t       w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    // Credits count in-flight ops plus FIFO entries, so every issued op has a slot.
    assign w_credit_ok = (r_credit_cnt < CNT_W'(QDEPTH));

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_scan        = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
            if (w_scan >= (ID_W + 1)'(NREQ)) begin
                w_scan = w_scan - (ID_W + 1)'(NREQ);
            end
            if (!w_grant_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_x   = '0;
        w_sel_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_x   = req_x[32*i +: 32];
                w_sel_tag = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    assign w_xfer     = w_credit_ok && w_grant_found;
    assign req_ready  = w_xfer ? (NREQ'(1) << w_grant_id) : '0;
    assign unit_x     = w_xfer ? w_sel_x : '0;
    assign w_pop      = res_valid && res_ready;
    assign w_next_sum = {1'b0, w_grant_id} + 1'b1;
    assign w_next_ptr = (w_next_sum >= (ID_W + 1)'(NREQ)) ? '0 : w_next_sum[ID_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_credit_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= w_next_ptr;
            end
            case ({w_xfer, w_pop})
                2'b10:   r_credit_cnt <= r_credit_cnt + 1'b1;
                2'b01:   r_credit_cnt <= r_credit_cnt - 1'b1;
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

    // Tag pipe mirrors the unit's register stages; clearing v on reset discards in-flight ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                r_tag_pipe[s] <= '0;
            end
        end else begin
            r_tag_pipe[0] <= '{v: w_xfer, id: w_grant_id, tag: w_sel_tag};
            for (int s = 1; s < LAT; s++) begin
                r_tag_pipe[s] <= r_tag_pipe[s-1];
            end
        end
    end

    assign w_push_data = '{y: unit_y, id: r_tag_pipe[LAT-1].id, tag: r_tag_pipe[LAT-1].tag};

    fpu_arb_fifo #(
        .WIDTH (RES_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_tag_pipe[LAT-1].v),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign res_valid = !w_fifo_empty;
    assign res_y     = w_head.y;
    assign res_id    = w_head.id;
    assign res_tag   = w_head.tag;

    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (rst)
        (r_credit_cnt >= w_fifo_count) && !(r_tag_pipe[LAT-1].v && w_fifo_full));

`ifdef FPU_ARB_STAT_EN
    logic [31:0] r_stat_issue [NREQ];
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat_issue[i] <= '0;
            end
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_xfer && (w_grant_id == ID_W'(i))) begin
                    r_stat_issue[i] <= r_stat_issue[i] + 1'b1;
                end
            end
            if ((|req_valid) && !w_credit_ok) begin
                r_stat_stall <= r_stat_stall + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat_out
        assign stat_issue[32*gi +: 32] = r_stat_issue[gi];
    end
    assign stat_stall = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_unit_arbiter.sv
// ============================================================================
// Module  : tb_fpu_unit_arbiter
// Brief   : Scoreboard bench for fpu_unit_arbiter (LAT=3/QDEPTH=4 plus a LAT=1 instance).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_unit_arbiter;

    localparam int NREQ   = 2;
    localparam int LAT    = 3;
    localparam int TAG_W  = 4;
    localparam int QDEPTH = 4;

    typedef struct packed {
        logic [31:0]      y;
        logic [0:0]       id;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*32-1:0]    req_x;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [31:0]           unit_x;
    logic [31:0]           unit_y;
    logic                  res_valid;
    logic                  res_ready;
    logic [31:0]           res_y;
    logic [0:0]            res_id;
    logic [TAG_W-1:0]      res_tag;
`ifdef FPU_ARB_STAT_EN
    logic [NREQ*32-1:0]    stat_issue;
    logic [31:0]           stat_stall;
    logic [NREQ*32-1:0]    d1_stat_issue;
    logic [31:0]           d1_stat_stall;
`endif

    // Default-parameter instance (LAT=1, QDEPTH=2)
    logic [1:0]  d1_req_valid;
    logic [1:0]  d1_req_ready;
    logic [63:0] d1_req_x;
    logic [7:0]  d1_req_tag;
    logic [31:0] d1_unit_x;
    logic [31:0] d1_unit_y;
    logic        d1_res_valid;
    logic        d1_res_ready;
    logic [31:0] d1_res_y;
    logic [0:0]  d1_res_id;
    logic [3:0]  d1_res_tag;

    int n_checks = 0;
    int n_errors = 0;

    fpu_unit_arbiter #(
        .NREQ(NREQ), .LAT(LAT), .TAG_W(TAG_W), .QDEPTH(QDEPTH)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_tag(req_tag),
        .unit_x(unit_x), .unit_y(unit_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_id(res_id), .res_tag(res_tag)
`ifdef FPU_ARB_STAT_EN
        , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
    );

    fpu_unit_arbiter u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_x(d1_req_x), .req_tag(d1_req_tag),
        .unit_x(d1_unit_x), .unit_y(d1_unit_y),
        .res_valid(d1_res_valid), .res_ready(d1_res_ready), .res_y(d1_res_y),
        .res_id(d1_res_id), .res_tag(d1_res_tag)
`ifdef FPU_ARB_STAT_EN
        , .stat_issue(d1_stat_issue), .stat_stall(d1_stat_stall)
`endif
    );

    // Positive float to integer, rounding toward minus infinity.
    function automatic logic [31:0] floor_f(input logic [31:0] x);
        int          e;
        logic [31:0] m;
        e = int'(x[30:23]);
        m = {8'd0, 1'b1, x[22:0]};
        if (e < 127) return 32'd0;
        if (e >= 150) return m << (e - 150);
        return m >> (150 - e);
    endfunction

    // Float just above integer k (1..65535) so floor gives back k.
    function automatic logic [31:0] mk_float(input int k);
        int          p;
        logic [31:0] mant;
        p = 0;
        for (int b = 0; b < 24; b++) if (k >= (1 << b)) p = b;
        mant    = 32'(k) << (23 - p);
        mant[0] = 1'b1;
        return {1'b0, 8'(127 + p), mant[22:0]};
    endfunction

    // Unit models: LAT register stages, free running, never reset.
    logic [31:0] unit_pipe [LAT];
    always @(posedge clk) begin
        unit_pipe[0] <= floor_f(unit_x);
        for (int s = 1; s < LAT; s++) unit_pipe[s] <= unit_pipe[s-1];
        d1_unit_y <= floor_f(d1_unit_x);
    end
    assign unit_y = unit_pipe[LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input int k, input logic [TAG_W-1:0] tag);
        req_valid[i]            = v;
        req_x[32*i +: 32]       = mk_float(k);
        req_tag[TAG_W*i +: TAG_W] = tag;
    endtask

    // Reference model state
    exp_t exp_q[$];
    int   m_cnt, m_ptr, m_occ, m_stall;
    int   m_issue [NREQ];
    logic [LAT-1:0] m_pv;
    int   obs_xfer [NREQ];

    always @(negedge clk) begin
        int             g;
        int             idx;
        logic           found, allowed, xfer, pop, push;
        logic [NREQ-1:0] exp_rdy;
        exp_t           e;
        if (rst) begin
            check_eq("rst_res_valid", 64'(res_valid), 64'd0);
            check_eq("rst_req_ready", 64'(req_ready), 64'd0);
            exp_q.delete();
            m_cnt = 0; m_ptr = 0; m_occ = 0; m_pv = '0; m_stall = 0;
            for (int i = 0; i < NREQ; i++) m_issue[i] = 0;
        end else begin
`ifdef FPU_ARB_STAT_EN
            check_eq("stat_issue0", 64'(stat_issue[31:0]), 64'(m_issue[0]));
            check_eq("stat_issue1", 64'(stat_issue[63:32]), 64'(m_issue[1]));
            check_eq("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
            allowed = (m_cnt < QDEPTH);
            found   = 1'b0;
            g       = 0;
            for (int i = 0; i < NREQ; i++) begin
                idx = (m_ptr + i) % NREQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            xfer    = found && allowed;
            exp_rdy = xfer ? NREQ'(1 << g) : '0;
            check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
            check_eq("unit_x", 64'(unit_x), xfer ? 64'(req_x[32*g +: 32]) : 64'd0);
            for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) obs_xfer[i]++;

            check_eq("res_valid", 64'(res_valid), 64'(m_occ != 0));
            pop = (m_occ != 0) && res_ready;
            if (m_occ != 0 && exp_q.size() > 0) begin
                check_eq("res_y", 64'(res_y), 64'(exp_q[0].y));
                check_eq("res_id", 64'(res_id), 64'(exp_q[0].id));
                check_eq("res_tag", 64'(res_tag), 64'(exp_q[0].tag));
                if (pop) void'(exp_q.pop_front());
            end
            push  = m_pv[LAT-1];
            m_occ = m_occ + int'(push) - int'(pop);
            m_pv  = (m_pv << 1) | LAT'(xfer);
            m_cnt = m_cnt + int'(xfer) - int'(pop);
            if (xfer) begin
                e.y   = floor_f(req_x[32*g +: 32]);
                e.id  = 1'(g);
                e.tag = req_tag[TAG_W*g +: TAG_W];
                exp_q.push_back(e);
                m_ptr = (g + 1) % NREQ;
                m_issue[g]++;
            end
            if ((|req_valid) && !allowed) m_stall++;
        end
    end

    initial begin
        int x0, x1, c;
        rst = 1'b1;
        req_valid = '0; req_x = '0; req_tag = '0; res_ready = 1'b0;
        d1_req_valid = '0; d1_req_x = '0; d1_req_tag = '0; d1_res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) obs_xfer[i] = 0;
        repeat (3) tick();
        check_eq("rst_res_y", 64'(res_y), 64'd0);
        check_eq("rst_res_id", 64'(res_id), 64'd0);
        check_eq("rst_res_tag", 64'(res_tag), 64'd0);
        check_eq("rst_unit_x", 64'(unit_x), 64'd0);

        // Single op on the LAT=1 instance: pi with tag 5 -> result 3 two cycles later.
        rst = 1'b0;
        d1_req_valid = 2'b01;
        d1_req_x     = {32'h0, 32'h40490FDB};
        d1_req_tag   = {4'd0, 4'd5};
        @(negedge clk);
        check_eq("d1_req_ready", 64'(d1_req_ready), 64'd1);
        check_eq("d1_unit_x", 64'(d1_unit_x), 64'h40490FDB);
        tick();
        d1_req_valid = 2'b00;
        @(negedge clk);
        check_eq("d1_valid_t1", 64'(d1_res_valid), 64'd0);
        tick();
        @(negedge clk);
        check_eq("d1_valid_t2", 64'(d1_res_valid), 64'd1);
        check_eq("d1_res_y", 64'(d1_res_y), 64'd3);
        check_eq("d1_res_id", 64'(d1_res_id), 64'd0);
        check_eq("d1_res_tag", 64'(d1_res_tag), 64'd5);
        tick();
        @(negedge clk);
        check_eq("d1_valid_t3", 64'(d1_res_valid), 64'd0);
        tick();

        // Single op on the main instance.
        res_ready = 1'b1;
        drive(0, 1'b1, 3, 4'd5);
        tick();
        drive(0, 1'b0, 0, 4'd0);
        repeat (8) tick();

        // Fairness: both requesters stream until eight grants.
        x0 = obs_xfer[0]; x1 = obs_xfer[1];
        for (c = 0; c < 60 && (obs_xfer[0] + obs_xfer[1] - x0 - x1) < 8; c++) begin
            drive(0, 1'b1, int'($urandom_range(1, 60000)), 4'($urandom));
            drive(1, 1'b1, int'($urandom_range(1, 60000)), 4'($urandom));
            tick();
        end
        req_valid = '0;
        check_eq("fair_req0", 64'(obs_xfer[0] - x0), 64'd4);
        check_eq("fair_req1", 64'(obs_xfer[1] - x1), 64'd4);
        repeat (10) tick();

        // Backpressure: exactly QDEPTH transfers, then drain in order.
        res_ready = 1'b0;
        x0 = obs_xfer[0];
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'b1, 100 + i, 4'(i));
            tick();
        end
        check_eq("bp_transfers", 64'(obs_xfer[0] - x0), 64'(QDEPTH));
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'b1, 200 + i, 4'(i + 3));
            tick();
        end
        req_valid = '0;
        repeat (12) tick();

        // Full-occupancy traffic with random consumer stalls.
        for (int i = 0; i < 60; i++) begin
            res_ready = (i >= 40) || ($urandom_range(0, 3) != 0);
            drive(0, 1'b1, int'($urandom_range(1, 60000)), 4'($urandom));
            drive(1, ($urandom_range(0, 4) != 0), int'($urandom_range(1, 60000)), 4'($urandom));
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (12) tick();

        // Reset mid-flight with FIFO occupied and ops still in the pipe.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 300 + i, 4'(i));
            tick();
        end
        check_eq("pre_rst_valid", 64'(res_valid), 64'd1);
        rst = 1'b1;
        req_valid = '0;
        #1;
        check_eq("midrst_res_valid", 64'(res_valid), 64'd0);
        check_eq("midrst_req_ready", 64'(req_ready), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        res_ready = 1'b1;
        drive(0, 1'b1, 77, 4'd9);
        tick();
        req_valid = '0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
